// File: rtl/servant_sleep_dummy_soc_pkg.sv
// Constants shared by the servant stand-in core: trap vector, the few instruction
// encodings it acts on, and its fetch/execute sequencing states.
package servant_sleep_dummy_soc_pkg;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam logic [31:0] MTVEC        = 32'h0000_0100;
    localparam logic [31:0] INSN_MRET    = 32'h3020_0073;
    localparam logic [31:0] INSN_MIE_SET = 32'h3004_6073;  // csrsi mstatus, 8
    localparam logic [31:0] INSN_MIE_CLR = 32'h3004_7073;  // csrci mstatus, 8
    localparam logic [6:0]  OP_JAL       = 7'h6f;
    localparam logic [6:0]  OP_STORE     = 7'h23;

    typedef enum logic [1:0] {
        CPU_FETCH = 2'd0,
        CPU_WAIT  = 2'd1,
        CPU_EXEC  = 2'd2
    } cpu_state_e;

    function automatic logic [31:0] jal_offset(input logic [31:0] insn);
        return {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/servant.sv
// Behavioural stand-in for the servant SoC (RAM, CPU, GPIO) keeping its hierarchy
// names; the core executes one instruction per 32/width cycles and decodes a small subset.
module servant_ram #(
    parameter int memsize = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adr,
    input  logic        cyc,
    input  logic        we,
    input  logic [31:0] wdat,
    output logic [31:0] rdt,
    output logic        ack
);

    localparam int aw = $clog2(memsize / 4);

    logic [31:0] mem [0:memsize/4-1];
    logic        unused_adr_bits;

    assign unused_adr_bits = ^{adr[31:aw+2], adr[1:0]};

    // Single-cycle acknowledge per request; reset only touches the handshake, never the contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack <= 1'b0;
        end else begin
            ack <= cyc & ~ack;
        end
        if (cyc && we) begin
            mem[adr[aw+1:2]] <= wdat;
        end
        rdt <= mem[adr[aw+1:2]];
    end

endmodule

module serv_top
    import servant_sleep_dummy_soc_pkg::*;
#(
    parameter int width    = 1,
    parameter int with_csr = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq,
    output logic [31:0] ibus_adr,
    output logic        ibus_cyc,
    input  logic [31:0] ibus_rdt,
    input  logic        ibus_ack,
    output logic        gpio_we,
    output logic        gpio_dat,
    output logic        mret
);

    localparam int exec_cycles = 32 / width;

    cpu_state_e  state_r;
    logic [31:0] pc_r;
    logic [31:0] mepc_r;
    logic [31:0] ir_r;
    logic        mie_r;
    logic [5:0]  cnt_r;
    logic        take_irq_s;

    // Interrupts are sampled between instructions; the mret cycle is skipped so a stale request cannot re-trap.
    assign take_irq_s = (with_csr != 0) && irq && mie_r && !mret;

    // Fetch / wait for RAM / serial execute; wfi and undecoded opcodes retire as nops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= CPU_FETCH;
            pc_r     <= RESET_PC;
            mepc_r   <= 32'h0000_0000;
            ir_r     <= 32'h0000_0000;
            mie_r    <= 1'b0;
            cnt_r    <= 6'd0;
            ibus_adr <= 32'h0000_0000;
            ibus_cyc <= 1'b0;
            gpio_we  <= 1'b0;
            gpio_dat <= 1'b0;
            mret     <= 1'b0;
        end else begin
            gpio_we <= 1'b0;
            mret    <= 1'b0;
            case (state_r)
                CPU_FETCH: begin
                    if (take_irq_s) begin
                        mepc_r <= pc_r;
                        pc_r   <= MTVEC;
                        mie_r  <= 1'b0;
                    end else begin
                        ibus_adr <= pc_r;
                        ibus_cyc <= 1'b1;
                        state_r  <= CPU_WAIT;
                    end
                end
                CPU_WAIT: begin
                    if (ibus_ack) begin
                        ibus_cyc <= 1'b0;
                        ir_r     <= ibus_rdt;
                        cnt_r    <= 6'd0;
                        state_r  <= CPU_EXEC;
                    end
                end
                CPU_EXEC: begin
                    if (cnt_r == 6'(exec_cycles - 1)) begin
                        state_r <= CPU_FETCH;
                        pc_r    <= pc_r + 32'd4;
                        if (ir_r == INSN_MRET) begin
                            pc_r  <= mepc_r;
                            mie_r <= 1'b1;
                            mret  <= 1'b1;
                        end else if (ir_r == INSN_MIE_SET) begin
                            mie_r <= 1'b1;
                        end else if (ir_r == INSN_MIE_CLR) begin
                            mie_r <= 1'b0;
                        end else if (ir_r[6:0] == OP_JAL) begin
                            pc_r <= pc_r + jal_offset(ir_r);
                        end else if (ir_r[6:0] == OP_STORE) begin
                            gpio_we  <= 1'b1;
                            gpio_dat <= (ir_r[24:20] != 5'd0);
                        end
                    end else begin
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                default: state_r <= CPU_FETCH;
            endcase
        end
    end

endmodule

module serv_rf_top #(
    parameter int width    = 1,
    parameter int with_csr = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq,
    output logic [31:0] ibus_adr,
    output logic        ibus_cyc,
    input  logic [31:0] ibus_rdt,
    input  logic        ibus_ack,
    output logic        gpio_we,
    output logic        gpio_dat,
    output logic        mret
);

    serv_top #(.width(width), .with_csr(with_csr)) cpu (
        .clk(clk), .rst(rst), .irq(irq),
        .ibus_adr(ibus_adr), .ibus_cyc(ibus_cyc), .ibus_rdt(ibus_rdt), .ibus_ack(ibus_ack),
        .gpio_we(gpio_we), .gpio_dat(gpio_dat), .mret(mret)
    );

endmodule

module servant #(
    parameter           memfile  = "",
    parameter int       memsize  = 8192,
    parameter int       width    = 1,
    parameter int       debug    = 0,
    parameter int       sim      = 0,
    parameter int       with_csr = 1,
    parameter bit [0:0] compress = 1'b0,
    parameter bit [0:0] align    = 1'b0
) (
    input  logic wb_clk,
    input  logic wb_rst,
    input  logic ext_irq,
    output logic q,
    output logic mret
);

    logic [31:0] wb_mem_adr;
    logic [31:0] wb_mem_rdt;
    logic        wb_mem_cyc;
    logic        wb_mem_ack;
    logic        gpio_we_s;
    logic        gpio_dat_s;
    logic        timer_irq_s;

    assign timer_irq_s = 1'b0;

    servant_ram #(.memsize(memsize)) ram (
        .clk(wb_clk), .rst(wb_rst), .adr(wb_mem_adr), .cyc(wb_mem_cyc),
        .we(1'b0), .wdat(32'h0000_0000), .rdt(wb_mem_rdt), .ack(wb_mem_ack)
    );

    serv_rf_top #(.width(width), .with_csr(with_csr)) cpu (
        .clk(wb_clk), .rst(wb_rst), .irq(timer_irq_s | ext_irq),
        .ibus_adr(wb_mem_adr), .ibus_cyc(wb_mem_cyc), .ibus_rdt(wb_mem_rdt), .ibus_ack(wb_mem_ack),
        .gpio_we(gpio_we_s), .gpio_dat(gpio_dat_s), .mret(mret)
    );

    // Single-bit GPIO output register.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            q <= 1'b0;
        end else if (gpio_we_s) begin
            q <= gpio_dat_s;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/servant_irq_cond.sv
// External-interrupt conditioning: two-flop synchronizer, rising-edge detect and a
// pending flag that only the handler's mret clears.
module servant_irq_cond (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    input  logic clr,
    output logic irq_out
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic pend_r;
    logic rise_s;

    assign rise_s  = sync2_r & ~prev_r;
    assign irq_out = pend_r;

    // Synchronize, keep the previous level, hold the request; a new edge beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            pend_r  <= 1'b0;
        end else begin
            sync1_r <= irq_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            if (rise_s) begin
                pend_r <= 1'b1;
            end else if (clr) begin
                pend_r <= 1'b0;
            end else begin
                pend_r <= pend_r;
            end
        end
    end

endmodule

// File: rtl/servant_sleep_dummy_soc.sv
// Servant SoC wrapper for sleep/interrupt experiments: WFI is a NOP and the clock is
// never gated; ext_irq becomes a registered pending request that the handler's mret clears.
module servant_sleep_dummy_soc #(
    parameter           memfile  = "",
    parameter int       memsize  = 8192,
    parameter int       width    = 1,
    parameter int       debug    = 0,
    parameter int       sim      = 0,
    parameter int       with_csr = 1,
    parameter bit [0:0] compress = 1'b0,
    parameter bit [0:0] align    = 1'b0
) (
    input  logic wb_clk,
    input  logic wb_rst,
    input  logic ext_irq,
    output logic q
);

    logic irq_pend;
    logic cpu_mret;

    servant_irq_cond irq_cond (
        .clk(wb_clk), .rst(wb_rst), .irq_in(ext_irq), .clr(cpu_mret), .irq_out(irq_pend)
    );

    servant #(
        .memfile(memfile), .memsize(memsize), .width(width), .debug(debug),
        .sim(sim), .with_csr(with_csr), .compress(compress), .align(align)
    ) servant (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .ext_irq(irq_pend), .q(q), .mret(cpu_mret)
    );

endmodule

// File: tb/tb_servant_sleep_dummy_soc.sv
// Directed + randomized bench: firmware preloaded into RAM, pending flag compared every
// cycle against an edge-indexed reference model, traps and mrets counted at the bus.
module tb_servant_sleep_dummy_soc;

    localparam logic [31:0] MTVEC  = 32'h0000_0100;
    localparam logic [31:0] I_MRET = 32'h3020_0073;
    localparam int          MAXE   = 20000;

    logic wb_clk = 1'b0;
    logic wb_rst = 1'b1;
    logic ext_irq = 1'b0;
    logic q;

    int   n_total = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    bit   in_at [0:MAXE-1];
    int   edge_n = 0;
    int   last_rst = 0;
    logic exp_pend = 1'b0;
    logic cap_in = 1'b0;
    logic cap_rst = 1'b1;
    logic cap_mret = 1'b0;
    int   traps = 0;
    int   mrets = 0;

    servant_sleep_dummy_soc #(.memsize(8192), .width(1)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .ext_irq(ext_irq), .q(q)
    );

    always #5 wb_clk = ~wb_clk;

    // Input level seen at edge k, counting anything at or before the latest reset edge as low.
    function automatic bit eff(input int k);
        if (k < 0 || k <= last_rst) return 1'b0;
        return in_at[k];
    endfunction

    // Inputs are stable between negedge and the following posedge.
    always @(negedge wb_clk) begin
        cap_in   = ext_irq;
        cap_rst  = wb_rst;
        cap_mret = dut.servant.cpu.cpu.mret;
    end

    // Reference: a 0->1 sampled at edge j raises pending at edge j+2; mret seen at edge m clears it; a set wins.
    always @(posedge wb_clk) begin
        if (edge_n < MAXE - 1) edge_n = edge_n + 1;
        in_at[edge_n] = cap_in;
        if (cap_rst) begin
            last_rst = edge_n;
            exp_pend = 1'b0;
        end else if (eff(edge_n - 2) && !eff(edge_n - 3)) begin
            exp_pend = 1'b1;
        end else if (cap_mret) begin
            exp_pend = 1'b0;
        end
        if (dut.servant.wb_mem_ack && dut.servant.wb_mem_adr == MTVEC) traps = traps + 1;
        if (dut.servant.cpu.cpu.mret) mrets = mrets + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic r, input logic i);
        @(posedge wb_clk);
        #1;
        wb_rst  = r;
        ext_irq = i;
        @(negedge wb_clk);
        chk("pend_model", {31'd0, dut.irq_pend}, {31'd0, exp_pend});
    endtask

    // kind: 0 trap taken, 1 mret seen, 2 q high, 3 q low, other: bus ack
    task automatic wait_evt(input string tag, input int kind, input int base, input int budget, input logic i);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < budget && !hit; n++) begin
            tick(1'b0, i);
            case (kind)
                0:       hit = (traps > base);
                1:       hit = (mrets > base);
                2:       hit = (q === 1'b1);
                3:       hit = (q === 1'b0);
                default: hit = (dut.servant.wb_mem_ack === 1'b1);
            endcase
        end
        chk(tag, {31'd0, hit}, 32'd1);
    endtask

    initial begin
        int t0;
        int m0;
        logic lvl;

        for (int w = 0; w < 128; w++) dut.servant.ram.mem[w] = 32'h0000_0013;
        dut.servant.ram.mem[0]  = 32'h3004_6073;  // enable MIE
        dut.servant.ram.mem[1]  = 32'h0011_0023;  // GPIO <= 1
        dut.servant.ram.mem[2]  = 32'h0001_0023;  // GPIO <= 0
        dut.servant.ram.mem[3]  = 32'h1050_0073;  // wfi
        dut.servant.ram.mem[4]  = 32'hffdf_f06f;  // jal x0, -4
        dut.servant.ram.mem[68] = I_MRET;         // ISR at 0x100: four nops then mret

        for (int n = 0; n < 10; n++) tick(1'b1, 1'b0);
        chk("q_reset", {31'd0, q}, 32'd0);
        chk("pend_reset", {31'd0, dut.irq_pend}, 32'd0);
        tick(1'b0, 1'b0);
        wait_evt("first_ack", 4, 0, 10, 1'b0);
        chk("first_adr", dut.servant.wb_mem_adr, 32'h0000_0000);

        wait_evt("gpio_high", 2, 0, 300, 1'b0);
        wait_evt("gpio_low", 3, 0, 300, 1'b0);
        for (int n = 0; n < 100; n++) tick(1'b0, 1'b0);

        t0 = traps; m0 = mrets;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("pend_latency", {31'd0, dut.irq_pend}, 32'd1);
        wait_evt("trap_taken", 0, t0, 100, 1'b0);
        wait_evt("mret_seen", 1, m0, 400, 1'b0);
        chk("pend_clr_mret", {31'd0, dut.irq_pend}, 32'd0);

        t0 = traps; m0 = mrets;
        for (int p = 0; p < 3; p++) begin
            tick(1'b0, 1'b1);
            for (int n = 0; n < 9; n++) tick(1'b0, 1'b0);
        end
        wait_evt("coal_mret", 1, m0, 600, 1'b0);
        for (int n = 0; n < 300; n++) tick(1'b0, 1'b0);
        chk("coal_traps", 32'(traps - t0), 32'd1);
        chk("coal_mrets", 32'(mrets - m0), 32'd1);
        chk("coal_pend", {31'd0, dut.irq_pend}, 32'd0);

        t0 = traps; m0 = mrets;
        wait_evt("held_mret", 1, m0, 600, 1'b1);
        for (int n = 0; n < 300; n++) tick(1'b0, 1'b1);
        chk("held_one_trap", 32'(traps - t0), 32'd1);
        chk("held_pend", {31'd0, dut.irq_pend}, 32'd0);
        for (int n = 0; n < 5; n++) tick(1'b0, 1'b0);
        wait_evt("held_retrigger", 0, t0 + 1, 100, 1'b1);
        chk("held_two_traps", 32'(traps - t0), 32'd2);
        wait_evt("held_mret2", 1, m0 + 1, 600, 1'b0);

        t0 = traps;
        for (int n = 0; n < 5; n++) tick(1'b1, 1'b1);
        for (int n = 0; n < 3; n++) tick(1'b1, 1'b0);
        chk("q_mid_reset", {31'd0, q}, 32'd0);
        for (int n = 0; n < 300; n++) tick(1'b0, 1'b0);
        chk("rstprio_traps", 32'(traps - t0), 32'd0);
        chk("rstprio_pend", {31'd0, dut.irq_pend}, 32'd0);
        chk("ram_kept", dut.servant.ram.mem[68], I_MRET);

        t0 = traps; m0 = mrets;
        for (int n = 0; n < 5; n++) tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("rise_from_reset", {31'd0, dut.irq_pend}, 32'd1);
        wait_evt("rfr_mret", 1, m0, 800, 1'b0);
        chk("rfr_traps", 32'(traps - t0), 32'd1);

        lvl = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 11) == 0) lvl = ~lvl;
            tick(1'b0, lvl);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
